// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA scan-out engine.
package vga_pkg;

  localparam int RGB_W = 12;

  // One complete raster description; porches and sync widths are in
  // clocks (horizontal) or lines (vertical).
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  // Per-pixel flags carried alongside the RAM read latency.
  typedef struct packed {
    logic act;  // pixel inside the visible area
    logic hs;   // horizontal sync asserted (polarity applied at the pin)
    logic vs;   // vertical sync asserted
    logic fs;   // pixel (0,0)
  } stage_t;

  function automatic int h_total(vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int v_total(vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters and stage-0 flags (active, sync windows, frame start).
// Also exposes the next counter values so the address register can be
// loaded in step with the counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter vga_timing_t T  = VGA_640X480,
  parameter int          HW = $clog2(h_total(T)),
  parameter int          VW = $clog2(v_total(T))
) (
  input  logic          clk_i,
  input  logic          srst_n_i,   // low = reset or scan-out disabled
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic [HW-1:0] h_nxt_o,
  output logic [VW-1:0] v_nxt_o,
  output logic          act_o,
  output logic          act_nxt_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          fs_o
);

  localparam int H_ACT  = T.h_active;
  localparam int V_ACT  = T.v_active;
  localparam int HS_BEG = T.h_active + T.h_fp;
  localparam int HS_END = T.h_active + T.h_fp + T.h_sync;
  localparam int VS_BEG = T.v_active + T.v_fp;
  localparam int VS_END = T.v_active + T.v_fp + T.v_sync;
  localparam logic [HW-1:0] H_LAST = HW'(h_total(T) - 1);
  localparam logic [VW-1:0] V_LAST = VW'(v_total(T) - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  function automatic logic in_win(int x, int lo, int hi);
    return (x >= lo) && (x < hi);
  endfunction

  // Advance one pixel; the last pixel of the last line wraps straight to (0,0).
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Counter registers; clearing parks the raster at (0,0).
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o       = h_q;
  assign v_o       = v_q;
  assign h_nxt_o   = h_d;
  assign v_nxt_o   = v_d;
  assign act_o     = (int'(h_q) < H_ACT) && (int'(v_q) < V_ACT);
  assign act_nxt_o = (int'(h_d) < H_ACT) && (int'(v_d) < V_ACT);
  assign hs_o      = in_win(int'(h_q), HS_BEG, HS_END);
  assign vs_o      = in_win(int'(v_q), VS_BEG, VS_END);
  assign fs_o      = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: incremental framebuffer address generation, flag pipeline
// matching the RAM read latency, and registered RGB/sync/blank pins.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int RAM_LAT     = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] address,
  input  logic [RGB_W-1:0]  q,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              blank,
  output logic              frame_start
);

  localparam vga_timing_t TIM = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };
  localparam int HT = h_total(TIM);
  localparam int VT = v_total(TIM);
  localparam int HW = (HT > 2) ? $clog2(HT) : 1;
  localparam int VW = (VT > 2) ? $clog2(VT) : 1;

  // Low-res framebuffer geometry.
  localparam int FB_W_I = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H_I = V_ACTIVE >> SCALE_SHIFT;
  localparam logic [ADDR_W-1:0] FB_W   = ADDR_W'(FB_W_I);
  localparam logic [VW-1:0]     V_MASK = VW'((1 << SCALE_SHIFT) - 1);
  // Lines at or beyond this one never advance row_base, which keeps it
  // at or below the start of the last framebuffer row.
  localparam int ROW_STOP = (FB_H_I - 1) << SCALE_SHIFT;

  if (longint'(FB_W_I) * longint'(FB_H_I) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("vga_scanout: framebuffer does not fit in ADDR_W address bits");
  end
  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
    $error("vga_scanout: RAM_LAT must be 1..4");
  end

  // Disable is a synchronous reset of the whole engine.
  logic clr_n;
  assign clr_n = reset_n & enable;

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          act0, act_nxt, hs0, vs0, fs0;

  vga_timing #(
    .T  (TIM),
    .HW (HW),
    .VW (VW)
  ) u_timing (
    .clk_i     (clock),
    .srst_n_i  (clr_n),
    .h_o       (h_cnt),
    .v_o       (v_cnt),
    .h_nxt_o   (h_nxt),
    .v_nxt_o   (v_nxt),
    .act_o     (act0),
    .act_nxt_o (act_nxt),
    .hs_o      (hs0),
    .vs_o      (vs0),
    .fs_o      (fs0)
  );

  // ---------------- address generation ----------------
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              row_done;

  // Last active pixel of the final replicated copy of a framebuffer row.
  assign row_done = (int'(h_cnt) == H_ACTIVE - 1) &&
                    ((v_cnt & V_MASK) == V_MASK) &&
                    (int'(v_cnt) < ROW_STOP);

  // Next row base and next address, computed from the next raster position
  // so the registered address lines up with the stage-0 counters.
  always_comb begin
    row_base_d = row_base_q;
    if (h_nxt == '0 && v_nxt == '0) begin
      row_base_d = '0;
    end else if (row_done) begin
      row_base_d = row_base_q + FB_W;
    end
    address_d = act_nxt ? row_base_d + ADDR_W'(h_nxt >> SCALE_SHIFT) : '0;
  end

  // Row base and read address registers.
  always_ff @(posedge clock) begin
    if (!clr_n) begin
      row_base_q <= '0;
      address_q  <= '0;
    end else begin
      row_base_q <= row_base_d;
      address_q  <= address_d;
    end
  end

  assign address = address_q;

  // ---------------- latency alignment ----------------
  // src is the flag set one clock before the output register, i.e. the
  // stage whose pixel data is on q right now.
  stage_t s0, src;
  assign s0 = '{act: act0, hs: hs0, vs: vs0, fs: fs0};

  if (RAM_LAT == 1) begin : g_nopipe
    assign src = s0;
  end else begin : g_pipe
    stage_t [RAM_LAT-1:1] pipe_q;

    // Shift the stage-0 flags toward the output register.
    always_ff @(posedge clock) begin
      if (!clr_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q[1] <= s0;
        for (int i = 2; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign src = pipe_q[RAM_LAT-1];
  end

  logic [RGB_W-1:0] rgb_q;
  logic             hs_q, vs_q, blank_q, fs_q;

  // Pin registers: RGB gated by the aligned active flag, syncs at pin polarity.
  always_ff @(posedge clock) begin
    if (!clr_n) begin
      rgb_q   <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= src.act ? q : '0;
      hs_q    <= src.hs ? HS_POL : ~HS_POL;
      vs_q    <= src.vs ? VS_POL : ~VS_POL;
      blank_q <= ~src.act;
      fs_q    <= src.fs;
    end
  end

  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances on a tiny 8x4 raster (12x7 totals),
// A with 1:1 mapping and low-active syncs, B with 2x replication and
// high-active syncs. A reference raster model pushes expected pin values
// into a scoreboard queue; they are popped RAM_LAT clocks later.
module tb_vga_scanout;

  localparam int L = 2;

  logic       clk = 1'b0;
  logic       reset_n, enable;
  logic [5:0] addr_a, addr_b;
  logic [11:0] q_a, q_b;
  logic [3:0] ra, ga, ba, rb, gb, bb;
  logic       hs_a, vs_a, bl_a, fs_a, hs_b, vs_b, bl_b, fs_b;

  typedef struct packed {
    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
    logic        hs_a, vs_a, hs_b, vs_b, blank, fs;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  int mh = 0, mv = 0, last_fs = -1, max_b = 0;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(0), .ADDR_W(6), .RAM_LAT(L)
  ) dut_a (
    .clock(clk), .reset_n(reset_n), .enable(enable), .address(addr_a), .q(q_a),
    .VGA_R(ra), .VGA_G(ga), .VGA_B(ba), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .blank(bl_a), .frame_start(fs_a)
  );

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .SCALE_SHIFT(1), .ADDR_W(6), .RAM_LAT(L)
  ) dut_b (
    .clock(clk), .reset_n(reset_n), .enable(enable), .address(addr_b), .q(q_b),
    .VGA_R(rb), .VGA_G(gb), .VGA_B(bb), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .blank(bl_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  // RAM model: data returns as the address itself, one register deep so
  // the pin register captures it RAM_LAT clocks after issue.
  always @(posedge clk) begin
    q_a <= {6'b0, addr_a};
    q_b <= {6'b0, addr_b};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int fb_a(int h, int v);
    return v * 8 + h;
  endfunction

  function automatic int fb_b(int h, int v);
    return (v / 2) * 4 + (h / 2);
  endfunction

  function automatic logic is_act(int h, int v);
    return (h < 8) && (v < 4);
  endfunction

  function automatic exp_t pix(int h, int v);
    exp_t e;
    logic act, hs_on, vs_on;
    act   = is_act(h, v);
    hs_on = (h >= 9) && (h < 11);
    vs_on = (v == 5);
    e.rgb_a = act ? 12'(fb_a(h, v)) : 12'h0;
    e.rgb_b = act ? 12'(fb_b(h, v)) : 12'h0;
    e.hs_a  = ~hs_on;
    e.vs_a  = ~vs_on;
    e.hs_b  = hs_on;
    e.vs_b  = vs_on;
    e.blank = ~act;
    e.fs    = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t rst_e();
    exp_t e;
    e.rgb_a = 12'h0;
    e.rgb_b = 12'h0;
    e.hs_a  = 1'b1;
    e.vs_a  = 1'b1;
    e.hs_b  = 1'b0;
    e.vs_b  = 1'b0;
    e.blank = 1'b1;
    e.fs    = 1'b0;
    return e;
  endfunction

  // One clock: advance the model using the controls sampled at this edge,
  // then compare every pin against the scoreboard and the address model.
  task automatic tick();
    bit   run;
    exp_t e;
    run = reset_n && enable;
    @(posedge clk);
    #1;
    cyc++;
    if (!run) begin
      mh = 0;
      mv = 0;
      last_fs = -1;
      sb.delete();
      repeat (L) sb.push_back(rst_e());
    end else if (mh == 11) begin
      mh = 0;
      mv = (mv == 6) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    e = sb.pop_front();
    chk("rgb_a",   32'({ra, ga, ba}), 32'(e.rgb_a));
    chk("rgb_b",   32'({rb, gb, bb}), 32'(e.rgb_b));
    chk("hs_a",    32'(hs_a), 32'(e.hs_a));
    chk("vs_a",    32'(vs_a), 32'(e.vs_a));
    chk("hs_b",    32'(hs_b), 32'(e.hs_b));
    chk("vs_b",    32'(vs_b), 32'(e.vs_b));
    chk("blank_a", 32'(bl_a), 32'(e.blank));
    chk("blank_b", 32'(bl_b), 32'(e.blank));
    chk("fs_a",    32'(fs_a), 32'(e.fs));
    chk("fs_b",    32'(fs_b), 32'(e.fs));
    chk("addr_a",  32'(addr_a), is_act(mh, mv) ? fb_a(mh, mv) : 0);
    chk("addr_b",  32'(addr_b), is_act(mh, mv) ? fb_b(mh, mv) : 0);
    sb.push_back(pix(mh, mv));
    if (int'(addr_b) > max_b) max_b = int'(addr_b);
    if (fs_a === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 84);
      last_fs = cyc;
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) tick();
    chk("rst_addr",  32'(addr_a), 0);
    chk("rst_hs_a",  32'(hs_a), 1);
    chk("rst_vs_b",  32'(vs_b), 0);
    chk("rst_blank", 32'(bl_a), 1);

    // Free-running: more than two full frames.
    reset_n = 1'b1;
    repeat (200) tick();

    // Abort mid-line 2 with a one-clock reset.
    n = 0;
    while (!(mh == 4 && mv == 2) && n < 200) begin
      tick();
      n++;
    end
    chk("reach_line2", 32'(n < 200), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_addr",  32'(addr_a), 0);
    chk("midrst_vs_a",  32'(vs_a), 1);
    chk("midrst_rgb",   32'({ra, ga, ba}), 0);
    chk("midrst_blank", 32'(bl_a), 1);
    tick();
    tick();
    chk("midrst_fs", 32'(fs_a), 1);
    repeat (150) tick();

    // Disable for five clocks, then resume.
    enable = 1'b0;
    repeat (5) begin
      tick();
      chk("dis_blank", 32'(bl_b), 1);
    end
    enable = 1'b1;
    chk("en_addr", 32'(addr_a), 0);
    tick();
    tick();
    chk("en_fs", 32'(fs_a), 1);
    repeat (200) tick();

    chk("max_addr_b", 32'(max_b), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
